// File: rtl/reg_file_2r1w_if.sv
// Register-file port bundle: one write port from WB, two registered read ports to ID.
// The master side is the pipeline; the slave side is the register file.
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write general-purpose register file with registered reads,
// stall hold, same-cycle write-to-read bypass and optional hardwired zero register.
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic             clk,
  input logic             rst,
  reg_file_2r1w_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  assign wr_ok = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero register has priority over bypass so a dropped write to r0 never leaks out.
  always_comb begin
    next_a = mem[bus.rd_addr_a];
    if (ZERO_REG && (bus.rd_addr_a == '0)) begin
      next_a = '0;
    end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      next_a = bus.wr_data;
    end
  end

  always_comb begin
    next_b = mem[bus.rd_addr_b];
    if (ZERO_REG && (bus.rd_addr_b == '0)) begin
      next_b = '0;
    end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      next_b = bus.wr_data;
    end
  end

  // Outputs only load on rd_en, so a stalled ID stage keeps its operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data_a <= next_a;
        bus.rd_data_b <= next_b;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: stimulus queues expected read data,
// a monitor pops and compares whenever rd_valid is presented.
module tb_reg_file_2r1w;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_count = 0;
  int   total_count = 0;
  exp_t sb_q[$];

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues the read result if reading.
  task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ea, input logic [31:0] eb, input string name);
    exp_t e;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_en     = re;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    if (re) begin
      e.a    = ea;
      e.b    = eb;
      e.name = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total_count++;
          $display("[TB] FAIL spurious_valid: got rd_valid=1, expected no read pending");
        end else begin
          e = sb_q.pop_front();
          check_output({e.name, "_a"}, bus.rd_data_a, e.a);
          check_output({e.name, "_b"}, bus.rd_data_b, e.b);
        end
      end
    end
  end

  initial begin
    logic [31:0] va;
    logic [31:0] vb;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_data_a", bus.rd_data_a, 32'h0);
    check_output("reset_valid", {31'h0, bus.rd_valid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset test: load r5, read it, then clear asynchronously mid-cycle.
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "pre_reset_wr");
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "pre_reset_rd");
    bus.rd_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_output("async_reset_a", bus.rd_data_a, 32'h0);
    check_output("async_reset_valid", {31'h0, bus.rd_valid}, 32'h0);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77;
    bus.rd_en = 1'b1; bus.rd_addr_a = 5'd5; bus.rd_addr_b = 5'd7;
    @(posedge clk);
    #1;
    check_output("in_reset_a", bus.rd_data_a, 32'h0);
    check_output("in_reset_valid", {31'h0, bus.rd_valid}, 32'h0);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    rst = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 32'h0, 32'h0, "post_reset_rd");

    // Basic read/write.
    apply_stimulus(1'b1, 5'd1, 32'h12345678, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_r1");
    apply_stimulus(1'b1, 5'd2, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_r2");
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 32'h12345678, 32'hCAFEF00D, "basic_rd");

    // Bypass: write and read r3 in the same cycle on both ports.
    apply_stimulus(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_r3");
    apply_stimulus(1'b1, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 5'd3, 32'hAAAA5555, 32'hAAAA5555, "bypass");
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd1, 32'hAAAA5555, 32'h12345678, "after_bypass");

    // Zero register ignores writes, including the bypass path.
    apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, "zero_same");
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd2, 32'h0, 32'hCAFEF00D, "zero_next");

    // Back-to-back writes to one address: last one wins.
    apply_stimulus(1'b1, 5'd6, 32'h1111, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_r6_first");
    apply_stimulus(1'b1, 5'd6, 32'h2222, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_r6_second");
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd6, 32'h2222, 32'h2222, "b2b_rd");

    // Stall: outputs hold while r4 is rewritten underneath them.
    apply_stimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "wr_r4");
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd1, 32'h44, 32'h12345678, "stall_pre");
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(k == 0, 5'd4, 32'h99, 1'b0, 5'd4, 5'd1, 32'h0, 32'h0, "stall");
      check_output($sformatf("stall_hold_a_%0d", k), bus.rd_data_a, 32'h44);
      check_output($sformatf("stall_hold_b_%0d", k), bus.rd_data_b, 32'h12345678);
      check_output($sformatf("stall_valid_%0d", k), {31'h0, bus.rd_valid}, 32'h0);
    end
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd1, 32'h99, 32'h12345678, "stall_release");

    // Sweep: fill r1..r31 then read complementary pairs.
    for (int i = 1; i < 32; i++) begin
      apply_stimulus(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "sweep_wr");
    end
    for (int i = 0; i < 32; i++) begin
      va = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
      vb = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101;
      apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i), va, vb, $sformatf("sweep_%0d", i));
    end
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "idle");

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      total_count++;
      $display("[TB] FAIL drain: got %0d reads still pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry by 32-bit general-purpose register file for the pipelined CPU.
- The ID stage reads two source operands on the A and B read ports; WB writes one result on the write port.
- Read ports are registered (1-cycle latency) and have a read-enable that holds the outputs during pipeline stalls.
- Write-to-read bypass gives same-cycle WB→ID forwarding. Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes; when 0, entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- wr_en  in  1  write strobe from WB.
- wr_addr  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  value to write.
- rd_en  in  1  read enable; 0 = ID stall, outputs hold.
- rd_addr_a  in  ADDR_W  source register A (rs).
- rd_addr_b  in  ADDR_W  source register B (rt).
- rd_data_a  out  DATA_W  registered read data A.
- rd_data_b  out  DATA_W  registered read data B.
- rd_valid  out  1  high the cycle after a sampled rd_en=1.

Behaviour:
- Reset: rst falling clears immediately, with no clock needed:
  - all entries = 0;
  - rd_data_a = rd_data_b = 0;
  - rd_valid = 0.
  - Entries and outputs stay cleared while rst=0. Writes and reads presented during reset are discarded.
- Write, at posedge with rst=1:
  - If wr_en=1 and !(ZERO_REG && wr_addr==0), then mem[wr_addr] <= wr_data.
  - A write to entry 0 with ZERO_REG=1 is silently dropped.
- Read, at posedge with rst=1 and rd_en=1, for each port X in {a, b} independently:
  - If ZERO_REG && rd_addr_X==0: rd_data_X <= 0.
  - Else if wr_en && wr_addr==rd_addr_X: rd_data_X <= wr_data (bypass; new value, never stale).
  - Else: rd_data_X <= mem[rd_addr_X].
- Latency: rd_data_X reflects the address sampled at edge N, visible after edge N.
- rd_valid <= rd_en at each posedge.
- Stall (rd_en=0):
  - rd_data_a and rd_data_b hold their previous values; the write port still operates.
  - A write during the stall to an address that was previously read does NOT update the held output. The pipeline's forwarding unit covers that case.
- Both ports may address the same register. Both return the same value, including when bypassed.
- Back-to-back writes to the same address: the last write wins. A read in the following cycle sees it from the array.
- Addresses are fully decoded; there is no out-of-range case.
- Reset asserted mid-stall or mid-write: immediate clear per the Reset rule; no partial write survives.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert rst=0 for one cycle, release, read A=r5 → rd_data_a=0 and rd_valid=0 during reset. Also, outputs go to 0 asynchronously before the next clk edge.
- Basic R/W: write r1=0x12345678 and r2=0xCAFEF00D on consecutive cycles, then rd_en=1 with A=r1, B=r2 → next cycle rd_data_a=0x12345678, rd_data_b=0xCAFEF00D, rd_valid=1.
- Bypass: r3 holds 0x1; in one cycle wr_en=1, wr_addr=3, wr_data=0xAAAA5555 with rd_en=1, A=B=r3 → both outputs =0xAAAA5555 after that edge.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, then read A=r0 in the same and next cycle → rd_data_a=0 both times.
- Stall hold: read A=r4 (0x44) giving rd_data_a=0x44, then rd_en=0 for 3 cycles while writing r4=0x99 → rd_data_a stays 0x44 and rd_valid=0. Then rd_en=1 → rd_data_a=0x99, rd_valid=1.
- Sweep: write r_i = i*0x01010101 for i=1..31, then read all pairs (i, 31-i) → every output matches, with r0 reading as 0.
